mkr_pin_mux_ctrl: RTL and testbench
===================================

Name: mkr_pin_mux_ctrl

Overview:
Sequences reconfiguration of the MKR header pins (AREF, A[6:0], D[14:0]) that are shared between SAM peripheral functions. Arbitrates pin-configuration requests from several requesters (round-robin). Applies each change with a break-before-make sequence: tri-state the pin, wait a dead time, switch the 2-bit mux select, then drive the requested output enable. Outputs feed the per-pin msel/enable logic of the pin-assignment block.

Parameters:
NUM_PINS, 23, number of managed pins; index 0 = AREF, 1..7 = A[6:0], 8..22 = D[14:0]
NUM_REQ, 2, number of requesters (1..8)
DEAD_CYCLES, 2, tri-state dwell before a mux switch; must be ≥1

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_pin  in  NUM_REQ*5  per-requester pin index; requester i uses bits [i*5+4:i*5]
req_msel  in  NUM_REQ*2  per-requester requested mux select
req_oe  in  NUM_REQ  per-requester requested output enable
req_ready  out  NUM_REQ  one-hot accept strobe
pin_msel  out  NUM_PINS*2  registered mux select; pin p uses bits [p*2+1:p*2]
pin_oe  out  NUM_PINS  registered output enable; 0 = tri-state
busy  out  1  sequence in progress
done  out  1  one-cycle pulse: change applied
err  out  1  one-cycle pulse: request rejected (pin ≥ NUM_PINS)

Behaviour:
- Reset (reset=0, async): pin_msel=0, pin_oe=0, busy=0, done=0, err=0, FSM=IDLE, RR pointer=NUM_REQ-1 (requester 0 has top priority first). Reset mid-sequence aborts immediately to these values.
- req_ready is combinational: asserted only in IDLE, only for the single granted requester with req_valid=1. A transfer occurs when valid&ready; the requester holds valid/pin/msel/oe stable until then.
- Arbitration: round-robin. Search starts at last granted+1, wrapping. The pointer updates on accept only.
- On accept, latch pin, msel and oe.
- FSM states: IDLE, BREAK, MAKE.
- IDLE -> error path: if pin ≥ NUM_PINS, stay IDLE; err=1 next cycle; no output changes.
- IDLE -> MAKE (skip break): if latched msel equals the current pin_msel[pin]. No tri-state phase in this path.
- IDLE -> BREAK: otherwise. pin_oe[pin] clears at the accept edge. Dwell counter loads DEAD_CYCLES.
- BREAK: counter decrements each cycle. On the edge ending the last BREAK cycle, pin_msel[pin] <= latched msel, then go to MAKE. BREAK lasts exactly DEAD_CYCLES cycles.
- MAKE: lasts 1 cycle. At its closing edge, pin_oe[pin] <= latched oe, done=1 for one cycle, then go to IDLE.
- busy=1 exactly while in BREAK or MAKE. It is 0 during IDLE, including the done and err cycles.
- A new accept is allowed in the same cycle done or err is high.
- Latency, accept cycle = 0:
  - Full path: oe cleared visible at cycle 1; msel visible at DEAD_CYCLES+1; oe and done at DEAD_CYCLES+2.
  - Skip path: oe and done at cycle 2.
  - Error path: err at cycle 1.
- Only the addressed pin changes. All other pin_msel/pin_oe bits hold.
- Requests withdrawn (valid dropped) before accept are never granted. Requests arriving while busy wait.

Test Plan:
(NUM_REQ=2, DEAD_CYCLES=2)
1. Reset values: assert reset low mid-clock with no clock edge -> pin_msel=0, pin_oe=0, busy/done/err=0 immediately.
2. Full path: from reset, req0 {pin=15, msel=3, oe=1}, accepted cycle 0 -> pin_oe[15]=0 cycles 1-3, busy=1 cycles 1-3, pin_msel[31:30]=3 from cycle 3, pin_oe[15]=1 and done=1 at cycle 4, busy=0 at cycle 4.
3. Skip path: then req0 {pin=15, msel=3, oe=0} -> no tri-state phase, busy=1 cycle 1 only, pin_oe[15]=0 and done=1 at cycle 2.
4. Arbitration: req0 and req1 valid simultaneously every cycle from reset -> grants alternate 0,1,0,1. No accept occurs while busy=1.
5. Error: req1 {pin=23} -> ready cycle 0, err=1 cycle 1, busy never set, all pin outputs unchanged.
6. Abort: reset asserted at cycle 2 of a full sequence -> all outputs 0 immediately. After release, a new request is granted to req0 first.

Source files
------------

// File: rtl/mkr_pin_mux_ctrl.sv
// Pin-mux reconfiguration sequencer for the shared MKR header pins.
// Round-robin request arbitration, then break-before-make: tri-state, dead time, switch msel, drive oe.
module mkr_pin_mux_ctrl #(
    parameter int NUM_PINS    = 23,
    parameter int NUM_REQ     = 2,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*5-1:0]    req_pin,
    input  logic [NUM_REQ*2-1:0]    req_msel,
    input  logic [NUM_REQ-1:0]      req_oe,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_PINS*2-1:0]   pin_msel,
    output logic [NUM_PINS-1:0]     pin_oe,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    // state   | meaning
    // S_IDLE  | waiting for a request; arbitration and accept happen here
    // S_BREAK | pin tri-stated, dead-time counter running
    // S_MAKE  | new msel in place, oe applied at the closing edge

    localparam int PIN_W = 5;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(DEAD_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_BREAK, S_MAKE} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_vld;
    logic [PIN_W-1:0]   g_pin;
    logic [1:0]         g_msel;
    logic               g_oe;
    logic [1:0]         cur_msel;
    logic               pin_ok;
    logic               need_break;
    logic               accept;
    logic [PIN_W-1:0]   pin_q;
    logic [1:0]         msel_q;
    logic               oe_q;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         msel_r [NUM_PINS];
    logic               oe_r   [NUM_PINS];

    // Search starts one past the last granted requester and wraps.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        g_pin    = '0;
        g_msel   = '0;
        g_oe     = 1'b0;
        cur_msel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                g_pin  = req_pin[i*PIN_W +: PIN_W];
                g_msel = req_msel[i*2 +: 2];
                g_oe   = req_oe[i];
            end
        end
        for (int p = 0; p < NUM_PINS; p++) begin
            if (g_pin == PIN_W'(p)) cur_msel = msel_r[p];
        end
    end

    assign pin_ok     = (int'(g_pin) < NUM_PINS);
    assign need_break = (g_msel != cur_msel);
    assign accept     = (state == S_IDLE) && grant_vld;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && pin_ok) state_nxt = need_break ? S_BREAK : S_MAKE;
            end
            S_BREAK: begin
                if (cnt == CNT_W'(1)) state_nxt = S_MAKE;
            end
            S_MAKE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= PTR_W'(NUM_REQ - 1);
            pin_q  <= '0;
            msel_q <= '0;
            oe_q   <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            for (int p = 0; p < NUM_PINS; p++) begin
                msel_r[p] <= '0;
                oe_r[p]   <= 1'b0;
            end
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        rr_ptr <= grant_idx;
                        pin_q  <= g_pin;
                        msel_q <= g_msel;
                        oe_q   <= g_oe;
                        if (!pin_ok) begin
                            err <= 1'b1;
                        end else if (need_break) begin
                            cnt <= CNT_W'(DEAD_CYCLES);
                            for (int p = 0; p < NUM_PINS; p++) begin
                                if (g_pin == PIN_W'(p)) oe_r[p] <= 1'b0;
                            end
                        end
                    end
                end
                S_BREAK: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        for (int p = 0; p < NUM_PINS; p++) begin
                            if (pin_q == PIN_W'(p)) msel_r[p] <= msel_q;
                        end
                    end
                end
                S_MAKE: begin
                    done <= 1'b1;
                    for (int p = 0; p < NUM_PINS; p++) begin
                        if (pin_q == PIN_W'(p)) oe_r[p] <= oe_q;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_flat
        assign pin_msel[p*2 +: 2] = msel_r[p];
        assign pin_oe[p]          = oe_r[p];
    end

endmodule

// File: tb/tb_mkr_pin_mux_ctrl.sv
// Directed bench for mkr_pin_mux_ctrl: reset, full/skip/error paths, round-robin and abort.
module tb_mkr_pin_mux_ctrl;

    logic        clock = 1'b0;
    logic        clk_en = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [9:0]  req_pin = '0;
    logic [3:0]  req_msel = '0;
    logic [1:0]  req_oe = '0;
    logic [1:0]  req_ready;
    logic [45:0] pin_msel;
    logic [22:0] pin_oe;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fails  = 0;

    logic [1:0] exp_ready [13] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00,
                                   2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    logic       exp_busy  [13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                                   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    mkr_pin_mux_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_pin   (req_pin),
        .req_msel  (req_msel),
        .req_oe    (req_oe),
        .req_ready (req_ready),
        .pin_msel  (pin_msel),
        .pin_oe    (pin_oe),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always begin
        #10;
        if (clk_en) clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input int r, input logic [4:0] pin, input logic [1:0] msel, input logic oe);
        req_valid[r]        = 1'b1;
        req_pin[r*5 +: 5]   = pin;
        req_msel[r*2 +: 2]  = msel;
        req_oe[r]           = oe;
    endtask

    initial begin
        // Reset with the clock stopped: values must appear without any edge.
        #5 reset = 1'b0;
        #1;
        chk("rst_msel", 64'(pin_msel), 64'd0);
        chk("rst_oe",   64'(pin_oe),   64'd0);
        chk("rst_busy", 64'(busy),     64'd0);
        chk("rst_done", 64'(done),     64'd0);
        chk("rst_err",  64'(err),      64'd0);
        clk_en = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Full path: pin 15, msel 0 -> 3, oe 1
        set_req(0, 5'd15, 2'd3, 1'b1);
        #1;
        chk("full_ready_c0", 64'(req_ready), 64'd1);
        chk("full_busy_c0",  64'(busy),      64'd0);
        @(negedge clock);
        req_valid = '0;
        chk("full_busy_c1",  64'(busy),          64'd1);
        chk("full_oe_c1",    64'(pin_oe[15]),    64'd0);
        chk("full_msel_c1",  64'(pin_msel),      64'd0);
        chk("full_ready_c1", 64'(req_ready),     64'd0);
        @(negedge clock);
        chk("full_busy_c2",  64'(busy),          64'd1);
        chk("full_msel_c2",  64'(pin_msel[31:30]), 64'd0);
        @(negedge clock);
        chk("full_busy_c3",  64'(busy),          64'd1);
        chk("full_msel_c3",  64'(pin_msel),      64'hC000_0000);
        chk("full_oe_c3",    64'(pin_oe[15]),    64'd0);
        chk("full_done_c3",  64'(done),          64'd0);
        @(negedge clock);
        chk("full_done_c4",  64'(done),          64'd1);
        chk("full_busy_c4",  64'(busy),          64'd0);
        chk("full_oe_c4",    64'(pin_oe),        64'h8000);

        // Skip path issued in the done cycle: same msel, oe -> 0
        set_req(0, 5'd15, 2'd3, 1'b0);
        #1;
        chk("skip_ready_c0", 64'(req_ready), 64'd1);
        @(negedge clock);
        req_valid = '0;
        chk("skip_busy_c1",  64'(busy),       64'd1);
        chk("skip_oe_c1",    64'(pin_oe[15]), 64'd1);
        chk("skip_done_c1",  64'(done),       64'd0);
        @(negedge clock);
        chk("skip_busy_c2",  64'(busy),       64'd0);
        chk("skip_done_c2",  64'(done),       64'd1);
        chk("skip_oe_c2",    64'(pin_oe),     64'd0);
        chk("skip_msel_c2",  64'(pin_msel),   64'hC000_0000);

        // Arbitration from reset with both requesters always valid
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        set_req(0, 5'd1, 2'd1, 1'b1);
        set_req(1, 5'd2, 2'd2, 1'b1);
        #1;
        for (int c = 0; c < 13; c++) begin
            chk($sformatf("arb_ready_c%0d", c), 64'(req_ready), 64'(exp_ready[c]));
            chk($sformatf("arb_busy_c%0d", c),  64'(busy),      64'(exp_busy[c]));
            if (c < 12) begin
                @(negedge clock);
                #1;
            end
        end
        req_valid = '0;
        #1;
        chk("arb_withdrawn_ready", 64'(req_ready), 64'd0);
        chk("arb_msel", 64'(pin_msel), 64'h24);
        chk("arb_oe",   64'(pin_oe),   64'h6);
        @(negedge clock);
        chk("arb_idle_busy", 64'(busy), 64'd0);

        // Error path: out-of-range pin from requester 1
        set_req(1, 5'd23, 2'd1, 1'b1);
        #1;
        chk("err_ready_c0", 64'(req_ready), 64'd2);
        @(negedge clock);
        req_valid = '0;
        chk("err_err_c1",  64'(err),      64'd1);
        chk("err_busy_c1", 64'(busy),     64'd0);
        chk("err_msel_c1", 64'(pin_msel), 64'h24);
        chk("err_oe_c1",   64'(pin_oe),   64'h6);
        @(negedge clock);
        chk("err_err_c2",  64'(err),      64'd0);
        chk("err_busy_c2", 64'(busy),     64'd0);

        // Abort: reset in cycle 2 of a full sequence granted to requester 0
        set_req(0, 5'd3, 2'd2, 1'b1);
        #1;
        chk("abort_ready_c0", 64'(req_ready), 64'd1);
        @(negedge clock);
        req_valid = '0;
        chk("abort_busy_c1", 64'(busy), 64'd1);
        @(negedge clock);
        chk("abort_busy_c2", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_msel", 64'(pin_msel), 64'd0);
        chk("abort_oe",   64'(pin_oe),   64'd0);
        chk("abort_busy", 64'(busy),     64'd0);
        chk("abort_done", 64'(done),     64'd0);
        chk("abort_err",  64'(err),      64'd0);
        @(negedge clock);
        reset = 1'b1;
        set_req(0, 5'd4, 2'd1, 1'b1);
        set_req(1, 5'd5, 2'd1, 1'b1);
        #1;
        chk("post_abort_ready", 64'(req_ready), 64'd1);
        @(negedge clock);
        req_valid = '0;
        chk("post_abort_busy_c1", 64'(busy), 64'd1);
        repeat (3) @(negedge clock);
        chk("post_abort_done_c4", 64'(done),     64'd1);
        chk("post_abort_oe_c4",   64'(pin_oe),   64'h10);
        chk("post_abort_msel_c4", 64'(pin_msel), 64'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
